// File: rtl/store_align_unit.sv
// Store alignment unit: turns a core store (rs2, byte address, Funct3) into
// word-aligned memory write beats with byte enables. Word-crossing stores are
// split into two beats, or rejected when ALLOW_MISALIGNED is 0.
module store_align_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [2:0]  Funct3,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;

  state_e      state;

  // Request decode, evaluated on the live request inputs at acceptance
  logic [3:0]  size_mask;
  logic [31:0] data_m;
  logic        illegal;
  logic [7:0]  wide_be;
  logic [63:0] wide_d;
  logic [31:0] base_addr;
  logic        crossing;
  logic        req_err;

  // Second-beat fields captured at acceptance
  logic [31:0] b1_addr;
  logic [31:0] b1_wdata;
  logic [3:0]  b1_be;
  logic        has_b1;

  // Decode access size; bytes beyond the size are zeroed so disabled lanes carry 0
  always_comb begin
    size_mask = 4'b0000;
    data_m    = 32'h0;
    illegal   = 1'b0;
    case (Funct3)
      3'b000: begin
        size_mask = 4'b0001;
        data_m    = {24'h0, data[7:0]};
      end
      3'b001: begin
        size_mask = 4'b0011;
        data_m    = {16'h0, data[15:0]};
      end
      3'b010: begin
        size_mask = 4'b1111;
        data_m    = data;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign wide_be   = {4'b0000, size_mask} << addr[1:0];
  assign wide_d    = {32'h0, data_m} << {addr[1:0], 3'b000};
  assign base_addr = {addr[31:2], 2'b00};
  assign crossing  = |wide_be[7:4];
  assign req_err   = illegal || (crossing && !ALLOW_MISALIGNED);

  // Control FSM with registered handshake, beat and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      req_ready <= 1'b1;
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'b0000;
      done      <= 1'b0;
      err       <= 1'b0;
      b1_addr   <= 32'h0;
      b1_wdata  <= 32'h0;
      b1_be     <= 4'b0000;
      has_b1    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        StIdle: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (req_err) begin
              // Rejected requests go straight to the response, no memory traffic
              state <= StResp;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= StBeat0;
              mem_valid <= 1'b1;
              mem_addr  <= base_addr;
              mem_wdata <= wide_d[31:0];
              mem_be    <= wide_be[3:0];
              b1_addr   <= base_addr + 32'd4;  // wraps modulo 2^32
              b1_wdata  <= wide_d[63:32];
              b1_be     <= wide_be[7:4];
              has_b1    <= crossing;
            end
          end
        end
        StBeat0: begin
          if (mem_ready) begin
            if (has_b1) begin
              state     <= StBeat1;
              mem_addr  <= b1_addr;
              mem_wdata <= b1_wdata;
              mem_be    <= b1_be;
            end else begin
              state     <= StResp;
              mem_valid <= 1'b0;
              mem_addr  <= 32'h0;
              mem_wdata <= 32'h0;
              mem_be    <= 4'b0000;
              done      <= 1'b1;
            end
          end
        end
        StBeat1: begin
          if (mem_ready) begin
            state     <= StResp;
            mem_valid <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'b0000;
            done      <= 1'b1;
          end
        end
        StResp: begin
          state     <= StIdle;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= StIdle;
          req_ready <= 1'b1;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
